// File: rtl/line_buffer_5rows.sv
// Raster-to-column converter: four COLS-deep row lines feeding five aligned taps.
// Optional frame counter output enabled by defining LB_FRAME_CNT_EN.
module line_buffer_5rows #(
  parameter int COLS = 7,
  parameter int ROWS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  S1_o,
  output logic [7:0]  S2_o,
  output logic [7:0]  S3_o,
  output logic [7:0]  S4_o,
  output logic [7:0]  S5_o,
  output logic        done_o,
`ifdef LB_FRAME_CNT_EN
  output logic [15:0] frame_cnt_o,
`endif
  output logic        progress_done_o
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_FULL = RW'(4);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  logic [7:0] line [4][COLS];

  logic accept;
  logic col_end;
  logic row_end;
  logic full;

  assign accept  = done_i & ~rst;
  assign col_end = (col_cnt == COL_LAST);
  assign row_end = (row_cnt == ROW_LAST);
  assign full    = (row_cnt >= ROW_FULL);

  // Raster position of the pixel being accepted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (done_i) begin
      if (col_end) begin
        col_cnt <= '0;
        row_cnt <= row_end ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Storage is left uncleared; done_o gating hides stale rows.
  always_ff @(posedge clk) begin
    if (accept) begin
      line[0][0] <= data_i;
      for (int k = 1; k < 4; k++) begin
        line[k][0] <= line[k-1][COLS-1];
      end
      for (int k = 0; k < 4; k++) begin
        for (int j = 1; j < COLS; j++) begin
          line[k][j] <= line[k][j-1];
        end
      end
    end
  end

  // Line tails hold the pixels 1..4 rows above the incoming one.
  always_ff @(posedge clk) begin
    if (rst) begin
      S1_o            <= '0;
      S2_o            <= '0;
      S3_o            <= '0;
      S4_o            <= '0;
      S5_o            <= '0;
      done_o          <= 1'b0;
      progress_done_o <= 1'b0;
    end else begin
      done_o          <= done_i & full;
      progress_done_o <= done_i & row_end & col_end;
      if (done_i && full) begin
        S1_o <= line[3][COLS-1];
        S2_o <= line[2][COLS-1];
        S3_o <= line[1][COLS-1];
        S4_o <= line[0][COLS-1];
        S5_o <= data_i;
      end
    end
  end

`ifdef LB_FRAME_CNT_EN
  // Steps on the same edge that raises progress_done_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_o <= '0;
    end else if (done_i && row_end && col_end) begin
      frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_buffer_5rows.sv
// Self-checking bench for line_buffer_5rows: directed tables plus
// randomized traffic against an image-array reference model.
module tb_line_buffer_5rows;

  localparam int COLS = 7;
  localparam int ROWS = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_i;
  logic [7:0]  data_i;
  logic [7:0]  S1_o, S2_o, S3_o, S4_o, S5_o;
  logic        done_o;
  logic        progress_done_o;
`ifdef LB_FRAME_CNT_EN
  logic [15:0] frame_cnt_o;
`endif

  line_buffer_5rows #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk             (clk),
    .rst             (rst),
    .done_i          (done_i),
    .data_i          (data_i),
    .S1_o            (S1_o),
    .S2_o            (S2_o),
    .S3_o            (S3_o),
    .S4_o            (S4_o),
    .S5_o            (S5_o),
    .done_o          (done_o),
`ifdef LB_FRAME_CNT_EN
    .frame_cnt_o     (frame_cnt_o),
`endif
    .progress_done_o (progress_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s1, s2, s3, s4, s5;
    int prog;
  } out_t;

  typedef struct {
    string name;
    int    idx;
    int    s1, s2, s3, s4, s5;
    int    prog;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: the current frame as a 2-D image.
  int img [ROWS][COLS];
  int mr, mc;
  int es [5];
  int edone, eprog;
  int efc;

  out_t log_q [$];
  out_t ref_q [$];

  task automatic chk(input string n, input int act, input int exp);
    total_cnt++;
    if (act != exp)
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic model_reset();
    mr = 0; mc = 0;
    edone = 0; eprog = 0; efc = 0;
    for (int k = 0; k < 5; k++) es[k] = 0;
  endtask

  task automatic model_accept(input int d);
    img[mr][mc] = d;
    edone = 0; eprog = 0;
    if (mr >= 4) begin
      for (int k = 0; k < 5; k++) es[k] = img[mr-4+k][mc];
      edone = 1;
      eprog = (mr == ROWS-1 && mc == COLS-1) ? 1 : 0;
      if (eprog == 1) efc = (efc + 1) % 65536;
    end
    mc++;
    if (mc == COLS) begin
      mc = 0;
      mr = (mr + 1) % ROWS;
    end
  endtask

  // One clock: drive, advance model, compare every output.
  task automatic cyc(input bit rs, input bit v, input int d);
    out_t o;
    rst = rs; done_i = v; data_i = d[7:0];
    @(posedge clk);
    if (rs) model_reset();
    else if (v) model_accept(d & 255);
    else begin
      edone = 0; eprog = 0;
    end
    #1;
    chk("done_o", int'(done_o), edone);
    chk("progress", int'(progress_done_o), eprog);
    chk("S1", int'(S1_o), es[0]);
    chk("S2", int'(S2_o), es[1]);
    chk("S3", int'(S3_o), es[2]);
    chk("S4", int'(S4_o), es[3]);
    chk("S5", int'(S5_o), es[4]);
`ifdef LB_FRAME_CNT_EN
    chk(eprog ? "fc_step" : "frame_cnt", int'(frame_cnt_o), efc);
`endif
    if (done_o) begin
      o.s1 = S1_o; o.s2 = S2_o; o.s3 = S3_o;
      o.s4 = S4_o; o.s5 = S5_o;
      o.prog = progress_done_o;
      log_q.push_back(o);
    end
  endtask

  task automatic chk_s(input string n, input int a, input int b,
                       input int c, input int d, input int e);
    chk({n, "_s1"}, int'(S1_o), a);
    chk({n, "_s2"}, int'(S2_o), b);
    chk({n, "_s3"}, int'(S3_o), c);
    chk({n, "_s4"}, int'(S4_o), d);
    chk({n, "_s5"}, int'(S5_o), e);
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{"first", 0, 1, 8, 15, 22, 29, 0};
    tbl[1] = '{"second", 1, 2, 9, 16, 23, 30, 0};
    tbl[2] = '{"row_end", 6, 7, 14, 21, 28, 35, 0};
    tbl[3] = '{"row_next", 7, 8, 15, 22, 29, 36, 0};
    tbl[4] = '{"last", 20, 21, 28, 35, 42, 49, 1};

    rst = 1'b1; done_i = 1'b0; data_i = '0;
    model_reset();
    #2;

    // Reset held two cycles with done_i high.
    cyc(1, 1, 99);
    cyc(1, 1, 98);
    chk("rst_done", int'(done_o), 0);
    chk_s("rst", 0, 0, 0, 0, 0);

    // Full frame, continuous.
    log_q.delete();
    for (int p = 1; p <= 49; p++) begin
      cyc(0, 1, p);
      if (p == 28) chk("pre29_cnt", log_q.size(), 0);
    end
    chk("frame_outs", log_q.size(), 21);
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].idx < log_q.size()) begin
        chk({tbl[i].name, "_s1"}, log_q[tbl[i].idx].s1, tbl[i].s1);
        chk({tbl[i].name, "_s2"}, log_q[tbl[i].idx].s2, tbl[i].s2);
        chk({tbl[i].name, "_s3"}, log_q[tbl[i].idx].s3, tbl[i].s3);
        chk({tbl[i].name, "_s4"}, log_q[tbl[i].idx].s4, tbl[i].s4);
        chk({tbl[i].name, "_s5"}, log_q[tbl[i].idx].s5, tbl[i].s5);
        chk({tbl[i].name, "_pg"}, log_q[tbl[i].idx].prog, tbl[i].prog);
      end else begin
        chk({tbl[i].name, "_missing"}, log_q.size(), tbl[i].idx + 1);
      end
    end
    ref_q = log_q;

    // Gap of three cycles after pixel 31.
    for (int p = 1; p <= 31; p++) cyc(0, 1, p);
    for (int g = 0; g < 3; g++) begin
      cyc(0, 0, 200);
      chk("gap_done", int'(done_o), 0);
      chk_s("gap_hold", 3, 10, 17, 24, 31);
    end
    cyc(0, 1, 32);
    chk("gap_resume", int'(done_o), 1);
    chk_s("gap_next", 4, 11, 18, 25, 32);
    for (int p = 33; p <= 49; p++) cyc(0, 1, p);

    // Back-to-back frames.
    for (int p = 1; p <= 49; p++) cyc(0, 1, p);
    log_q.delete();
    for (int p = 101; p <= 149; p++) begin
      cyc(0, 1, p);
      if (p == 128) chk("b2b_quiet", log_q.size(), 0);
    end
    chk("b2b_outs", log_q.size(), 21);
    if (log_q.size() > 0) begin
      chk("b2b_s1", log_q[0].s1, 101);
      chk("b2b_s2", log_q[0].s2, 108);
      chk("b2b_s3", log_q[0].s3, 115);
      chk("b2b_s4", log_q[0].s4, 122);
      chk("b2b_s5", log_q[0].s5, 129);
    end

    // Reset mid-frame after pixel 20, then a full frame.
    for (int p = 1; p <= 20; p++) cyc(0, 1, p);
    cyc(1, 0, 0);
    log_q.delete();
    for (int p = 1; p <= 49; p++) cyc(0, 1, p);
    chk("rstmid_outs", log_q.size(), ref_q.size());
    for (int i = 0; i < log_q.size() && i < ref_q.size(); i++) begin
      chk("rstmid_s1", log_q[i].s1, ref_q[i].s1);
      chk("rstmid_s5", log_q[i].s5, ref_q[i].s5);
      chk("rstmid_pg", log_q[i].prog, ref_q[i].prog);
    end

`ifdef LB_FRAME_CNT_EN
    // Two fresh frames: counter 0 -> 1 -> 2.
    cyc(1, 0, 0);
    chk("fc_zero", int'(frame_cnt_o), 0);
    for (int f = 0; f < 2; f++)
      for (int p = 1; p <= 49; p++) cyc(0, 1, p);
    chk("fc_two", int'(frame_cnt_o), 2);
`endif

    // Randomized traffic with gaps and rare resets.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
